// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer
//   Receive-side framer ahead of the FCS checker. Strips preamble/SFD from the raw
//   PHY byte stream and re-emits the frame bytes (FCS included) through a 4-byte
//   delay line, so the first FCS byte can be flagged the cycle rx_dv drops.
//   Also reports the frame length and a length/PHY error status once per frame.
//
// Ports
//   i_clk             clock, rising edge
//   i_rst_n           asynchronous active-low reset
//   i_rx_dv           PHY receive data valid
//   i_rx_er           PHY receive error
//   i_rxd[7:0]        PHY receive byte
//   o_start_of_frame  1-cycle pulse the cycle before the first frame byte
//   o_end_of_frame    1-cycle pulse with the first FCS byte
//   o_data_out[7:0]   frame byte, 0 when o_data_valid is low
//   o_data_valid      o_data_out carries a frame byte
//   o_frame_done      1-cycle pulse with the last frame byte
//   o_frame_len       bytes after SFD incl. FCS, held until the next o_frame_done
//   o_frame_err       runt, oversize or rx_er seen; held until the next o_frame_done
module gmii_rx_framer #(
  parameter int unsigned MIN_PREAMBLE  = 1,
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1522,
  parameter int unsigned LEN_WIDTH     = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_dv,
  input  logic                 i_rx_er,
  input  logic [7:0]           i_rxd,
  output logic                 o_start_of_frame,
  output logic                 o_end_of_frame,
  output logic [7:0]           o_data_out,
  output logic                 o_data_valid,
  output logic                 o_frame_done,
  output logic [LEN_WIDTH-1:0] o_frame_len,
  output logic                 o_frame_err
);

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StPreamble,
    StData,
    StDrain
  } state_e;

  state_e               r_state, w_state_nxt;
  logic [7:0]           r_pcnt, w_pcnt_nxt;
  logic [LEN_WIDTH-1:0] r_len, w_len_nxt;
  logic                 r_err, w_err_nxt;
  logic [1:0]           r_drain_cnt, w_drain_cnt_nxt;
  // r_dly[0] holds the newest byte, r_dly[3] the byte due on data_out
  logic [3:0][7:0]      r_dly, w_dly_nxt;

  logic                 r_sof, w_sof_nxt;
  logic                 r_eof, w_eof_nxt;
  logic [7:0]           r_data, w_data_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_done, w_done_nxt;
  logic [LEN_WIDTH-1:0] r_flen, w_flen_nxt;
  logic                 r_ferr, w_ferr_nxt;

  logic                 w_shift;
  logic [7:0]           w_shift_in;
  logic                 w_len_bad;

  assign w_len_bad = (r_len < LEN_WIDTH'(MIN_FRAME_LEN)) | (r_len > LEN_WIDTH'(MAX_FRAME_LEN));

  always_comb begin
    w_state_nxt     = r_state;
    w_pcnt_nxt      = r_pcnt;
    w_len_nxt       = r_len;
    w_err_nxt       = r_err;
    w_drain_cnt_nxt = r_drain_cnt;
    w_shift         = 1'b0;
    w_shift_in      = 8'h00;
    w_sof_nxt       = 1'b0;
    w_eof_nxt       = 1'b0;
    w_data_nxt      = 8'h00;
    w_valid_nxt     = 1'b0;
    w_done_nxt      = 1'b0;
    w_flen_nxt      = r_flen;
    w_ferr_nxt      = r_ferr;

    unique case (r_state)
      StWaitIdle: begin
        if (!i_rx_dv) w_state_nxt = StIdle;
      end
      StIdle: begin
        if (i_rx_dv) begin
          if (i_rxd == 8'h55) begin
            w_state_nxt = StPreamble;
            w_pcnt_nxt  = 8'd1;
          end else begin
            w_state_nxt = StWaitIdle;
          end
        end
      end
      StPreamble: begin
        if (!i_rx_dv) begin
          w_state_nxt = StIdle;
        end else if (i_rxd == 8'h55) begin
          if (r_pcnt != 8'hff) w_pcnt_nxt = r_pcnt + 8'd1;
        end else if (i_rxd == 8'hd5 && r_pcnt >= 8'(MIN_PREAMBLE)) begin
          w_state_nxt = StData;
          w_len_nxt   = '0;
          w_err_nxt   = 1'b0;
        end else begin
          w_state_nxt = StWaitIdle;
        end
      end
      StData: begin
        if (i_rx_dv) begin
          w_shift    = 1'b1;
          w_shift_in = i_rxd;
          if (r_len != '1) w_len_nxt = r_len + 1'b1;
          if (i_rx_er) w_err_nxt = 1'b1;
          // Fourth byte entering the line: first byte leaves next cycle
          if (r_len == LEN_WIDTH'(3)) w_sof_nxt = 1'b1;
          if (r_len >= LEN_WIDTH'(4)) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_dly[3];
          end
        end else if (r_len >= LEN_WIDTH'(4)) begin
          // Last four bytes in the line are the FCS; first of them goes out now
          w_valid_nxt     = 1'b1;
          w_data_nxt      = r_dly[3];
          w_eof_nxt       = 1'b1;
          w_shift         = 1'b1;
          w_drain_cnt_nxt = 2'd0;
          w_state_nxt     = StDrain;
        end else begin
          // Runt too short to hold an FCS: report only, nothing on data_out
          w_done_nxt  = 1'b1;
          w_flen_nxt  = r_len;
          w_ferr_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      StDrain: begin
        w_valid_nxt     = 1'b1;
        w_data_nxt      = r_dly[3];
        w_shift         = 1'b1;
        w_drain_cnt_nxt = r_drain_cnt + 2'd1;
        if (r_drain_cnt == 2'd2) begin
          w_done_nxt  = 1'b1;
          w_flen_nxt  = r_len;
          w_ferr_nxt  = w_len_bad | r_err;
          w_state_nxt = i_rx_dv ? StWaitIdle : StIdle;
        end
      end
      default: begin
        w_state_nxt = StWaitIdle;
      end
    endcase

    w_dly_nxt = w_shift ? {r_dly[2:0], w_shift_in} : r_dly;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StWaitIdle;
      r_pcnt      <= 8'd0;
      r_len       <= '0;
      r_err       <= 1'b0;
      r_drain_cnt <= 2'd0;
      r_dly       <= '0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_flen      <= '0;
      r_ferr      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pcnt      <= w_pcnt_nxt;
      r_len       <= w_len_nxt;
      r_err       <= w_err_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_dly       <= w_dly_nxt;
      r_sof       <= w_sof_nxt;
      r_eof       <= w_eof_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_done      <= w_done_nxt;
      r_flen      <= w_flen_nxt;
      r_ferr      <= w_ferr_nxt;
    end
  end

  assign o_start_of_frame = r_sof;
  assign o_end_of_frame   = r_eof;
  assign o_data_out       = r_data;
  assign o_data_valid     = r_valid;
  assign o_frame_done     = r_done;
  assign o_frame_len      = r_flen;
  assign o_frame_err      = r_ferr;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Bench for gmii_rx_framer: the driver pushes expected output events (with the cycle
// they must appear on) into queues; a negedge monitor pops and compares them.
module tb_gmii_rx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        sof, eof, dvalid, done, ferr;
  logic [7:0]  dout;
  logic [10:0] flen;

  gmii_rx_framer #(
    .MIN_PREAMBLE (1),
    .MIN_FRAME_LEN(64),
    .MAX_FRAME_LEN(1522),
    .LEN_WIDTH    (11)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_rx_dv         (rx_dv),
    .i_rx_er         (rx_er),
    .i_rxd           (rxd),
    .o_start_of_frame(sof),
    .o_end_of_frame  (eof),
    .o_data_out      (dout),
    .o_data_valid    (dvalid),
    .o_frame_done    (done),
    .o_frame_len     (flen),
    .o_frame_err     (ferr)
  );

  always #5 clk = ~clk;

  // cyc = index of the most recent rising edge
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic        eof;
  } exp_data_t;

  typedef struct {
    int unsigned cyc;
    logic [10:0] len;
    logic        err;
  } exp_done_t;

  exp_data_t   data_q[$];
  exp_done_t   done_q[$];
  int unsigned sof_q[$];
  logic [10:0] held_len = '0;
  logic        held_err = 1'b0;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_data_t   ed;
    exp_done_t   ee;
    int unsigned es;
    if (sof || (sof_q.size() > 0 && sof_q[0] == cyc)) begin
      es = 0;
      if (sof_q.size() > 0) es = sof_q.pop_front();
      check_eq("sof", {31'd0, sof, cyc}, {31'd0, 1'b1, es});
    end
    if (dvalid || (data_q.size() > 0 && data_q[0].cyc == cyc)) begin
      ed.cyc = 0; ed.data = 8'h00; ed.eof = 1'b0;
      if (data_q.size() > 0) ed = data_q.pop_front();
      check_eq("data", {22'd0, dvalid, eof, dout, cyc}, {22'd0, 1'b1, ed.eof, ed.data, ed.cyc});
    end else begin
      check_eq("idle_out", {55'd0, eof, dout}, 64'd0);
    end
    if (done || (done_q.size() > 0 && done_q[0].cyc == cyc)) begin
      ee.cyc = 0; ee.len = '0; ee.err = 1'b0;
      if (done_q.size() > 0) ee = done_q.pop_front();
      check_eq("frame_done", {19'd0, done, ferr, flen, cyc}, {19'd0, 1'b1, ee.err, ee.len, ee.cyc});
      held_len = ee.len;
      held_err = ee.err;
    end else begin
      check_eq("held_status", {52'd0, ferr, flen}, {52'd0, held_err, held_len});
    end
  end

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(negedge clk);
    rx_dv = dv;
    rx_er = er;
    rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    data_q.delete();
    done_q.delete();
    sof_q.delete();
    held_len = '0;
    held_err = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_outs", {42'd0, sof, eof, dout, dvalid, done, flen, ferr}, 64'd0);
    #1;
    rst_n = 1'b1;
  endtask

  // kind: 0 = good preamble, 1 = 55 55 5A D5, 2 = bare D5
  task automatic send_frame(input int len, input int er_at, input int rst_at, input int kind,
                            input bit crc_tail);
    logic [31:0] tail;
    logic [7:0]  b;
    bit          live;
    bit          er_seen;
    int unsigned t;
    int          k;
    tail    = 32'he6c53db2;
    live    = (kind == 0);
    er_seen = 1'b0;
    if (kind == 0) begin
      repeat (7) drive(1'b1, 1'b0, 8'h55);
    end else if (kind == 1) begin
      drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'h5a);
    end
    drive(1'b1, 1'b0, 8'hd5);
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        do_reset();
        live = 1'b0;
      end
      if (crc_tail && i >= len - 4) begin
        k = i - (len - 4);
        b = tail[31 - 8*k -: 8];
      end else begin
        b = 8'($urandom_range(0, 255));
      end
      drive(1'b1, i == er_at, b);
      t = cyc + 1;
      if (i == er_at) er_seen = 1'b1;
      if (live && len >= 4) begin
        data_q.push_back('{cyc: t + 4, data: b, eof: (i == len - 4)});
        if (i == 3) sof_q.push_back(t);
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    t = cyc + 1;
    if (live) begin
      done_q.push_back('{cyc: (len >= 4) ? t + 3 : t,
                         len: (len > 2047) ? 11'h7ff : 11'(len),
                         err: (len < 64) || (len > 1522) || er_seen});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("reset_state", {42'd0, sof, eof, dout, dvalid, done, flen, ferr}, 64'd0);
    #1;
    rst_n = 1'b1;
    idle(4);

    // Good 72-byte frame with the CRC tail
    send_frame(72, -1, -1, 0, 1'b1);
    idle(11);
    // Runts
    send_frame(20, -1, -1, 0, 1'b0);
    idle(11);
    send_frame(3, -1, -1, 0, 1'b0);
    idle(11);
    send_frame(1, -1, -1, 0, 1'b0);
    idle(11);
    send_frame(4, -1, -1, 0, 1'b0);
    idle(11);
    // rx_er mid-frame
    send_frame(72, 30, -1, 0, 1'b0);
    idle(11);
    // Bad preamble, missing preamble, then a good frame
    send_frame(30, -1, -1, 1, 1'b0);
    idle(11);
    send_frame(30, -1, -1, 2, 1'b0);
    idle(11);
    send_frame(64, -1, -1, 0, 1'b1);
    idle(11);
    // Reset mid-frame, released with rx_dv still high
    send_frame(72, -1, 40, 0, 1'b0);
    idle(11);
    send_frame(72, -1, -1, 0, 1'b1);
    idle(11);
    // Back-to-back 64-byte frames, 12-cycle gap
    send_frame(64, -1, -1, 0, 1'b0);
    idle(11);
    send_frame(64, -1, -1, 0, 1'b1);
    idle(11);
    // Length boundaries
    send_frame(63, -1, -1, 0, 1'b0);
    idle(11);
    send_frame(1522, -1, -1, 0, 1'b0);
    idle(11);
    send_frame(1523, -1, -1, 0, 1'b0);
    idle(20);

    check_eq("leftover_exp", 64'(data_q.size() + done_q.size() + sof_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
